// File: rtl/vectored_int_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM state encoding
// and default vector placement.
package vectored_int_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } vic_state_e;

    localparam logic [31:0] VIC_VEC_BASE_DEF  = 32'h0000_0100;
    localparam int          VIC_VEC_SHIFT_DEF = 4;

endpackage

// File: rtl/vectored_int_ctrl_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins; id is 0 when idle.
module vic_prio_enc
    import vectored_int_ctrl_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    output logic              o_valid,
    output logic [ID_W-1:0]   o_id
);

    // Scan from the top down so the lowest-index request is the last one written.
    always_comb begin
        o_valid = |i_req;
        o_id    = {ID_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            o_id = i_req[i] ? ID_W'(i) : o_id;
        end
    end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: edge-latched pending bits, mask, global enable,
// single-level service FSM with EPC capture and a one-cycle device acknowledge.
module vectored_int_ctrl
    import vectored_int_ctrl_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] VEC_BASE  = VIC_VEC_BASE_DEF,
    parameter int          VEC_SHIFT = VIC_VEC_SHIFT_DEF,
    localparam int         ID_W      = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_irq_in,
    input  logic              i_mask_we,
    input  logic [NUM_CH-1:0] i_mask_wd,
    input  logic              i_status_we,
    input  logic              i_status_wd,
    input  logic              i_eret,
    input  logic [ADDR_W-1:0] i_pc_next,
    output logic              o_int_take,
    output logic [ADDR_W-1:0] o_vec_addr,
    output logic [ADDR_W-1:0] o_epc,
    output logic [ID_W-1:0]   o_int_id,
    output logic              o_in_service,
    output logic              o_status_bit,
    output logic [NUM_CH-1:0] o_pending,
    output logic [NUM_CH-1:0] o_irq_ack
);

    localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

    vic_state_e          r_state;
    vic_state_e          w_state_nxt;
    logic [NUM_CH-1:0]   r_irq_prev;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_mask;
    logic                r_gie;
    logic [ADDR_W-1:0]   r_epc;
    logic [ID_W-1:0]     r_int_id;
    logic [NUM_CH-1:0]   r_irq_ack;

    logic [NUM_CH-1:0]   w_rise;
    logic [NUM_CH-1:0]   w_req;
    logic                w_req_valid;
    logic [ID_W-1:0]     w_sel_id;
    logic [NUM_CH-1:0]   w_sel_onehot;
    logic [NUM_CH-1:0]   w_clr;
    logic                w_take;

    assign w_rise       = i_irq_in & ~r_irq_prev;
    assign w_req        = r_pending & r_mask;
    assign w_sel_onehot = CH_ONE << w_sel_id;
    assign w_clr        = w_take ? w_sel_onehot : {NUM_CH{1'b0}};

    vic_prio_enc #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_prio_enc (
        .i_req   (w_req),
        .o_valid (w_req_valid),
        .o_id    (w_sel_id)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A take is blocked in the eret cycle so the instruction at the return address retires first.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_gie && w_req_valid && !i_eret) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SERVICE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (i_eret) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // New edges are OR-ed in after the clear, so a set in the clearing cycle survives.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq_prev <= {NUM_CH{1'b0}};
            r_pending  <= {NUM_CH{1'b0}};
            r_mask     <= {NUM_CH{1'b0}};
            r_gie      <= 1'b0;
        end else begin
            r_irq_prev <= i_irq_in;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            r_mask     <= i_mask_we ? i_mask_wd : r_mask;
            r_gie      <= i_status_we ? i_status_wd : r_gie;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_epc     <= {ADDR_W{1'b0}};
            r_int_id  <= {ID_W{1'b0}};
            r_irq_ack <= {NUM_CH{1'b0}};
        end else if (w_take) begin
            r_epc     <= i_pc_next;
            r_int_id  <= w_sel_id;
            r_irq_ack <= w_sel_onehot;
        end else begin
            r_epc     <= r_epc;
            r_int_id  <= r_int_id;
            r_irq_ack <= {NUM_CH{1'b0}};
        end
    end

    assign o_int_take   = w_take;
    assign o_vec_addr   = ADDR_W'(VEC_BASE) + (ADDR_W'(w_sel_id) << VEC_SHIFT);
    assign o_epc        = r_epc;
    assign o_int_id     = r_int_id;
    assign o_in_service = (r_state == ST_SERVICE);
    assign o_status_bit = r_gie;
    assign o_pending    = r_pending;
    assign o_irq_ack    = r_irq_ack;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Directed table-driven bench for vectored_int_ctrl (NUM_CH=4, base 0x100, 16-byte spacing).
module tb_vectored_int_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic        status_we;
    logic        status_wd;
    logic        eret;
    logic [31:0] pc_next;
    logic        int_take;
    logic [31:0] vec_addr;
    logic [31:0] epc;
    logic [1:0]  int_id;
    logic        in_service;
    logic        status_bit;
    logic [3:0]  pending;
    logic [3:0]  irq_ack;

    int n_vec = 0;
    int n_err = 0;

    vectored_int_ctrl #(
        .NUM_CH    (4),
        .ADDR_W    (32),
        .VEC_BASE  (32'h0000_0100),
        .VEC_SHIFT (4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_irq_in     (irq_in),
        .i_mask_we    (mask_we),
        .i_mask_wd    (mask_wd),
        .i_status_we  (status_we),
        .i_status_wd  (status_wd),
        .i_eret       (eret),
        .i_pc_next    (pc_next),
        .o_int_take   (int_take),
        .o_vec_addr   (vec_addr),
        .o_epc        (epc),
        .o_int_id     (int_id),
        .o_in_service (in_service),
        .o_status_bit (status_bit),
        .o_pending    (pending),
        .o_irq_ack    (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  irq;
        logic        mwe;
        logic [3:0]  mwd;
        logic        swe;
        logic        swd;
        logic        eret;
        logic [31:0] pc;
        logic        take;
        logic [31:0] vec;   // 0 = not checked
        logic [31:0] epc;
        logic [1:0]  id;
        logic        insvc;
        logic        gie;
        logic [3:0]  pend;
        logic [3:0]  ack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rst, logic [3:0] irq, logic mwe, logic [3:0] mwd,
                               logic swe, logic swd, logic er, logic [31:0] pc,
                               logic take, logic [31:0] va, logic [31:0] e, logic [1:0] id,
                               logic insvc, logic gie, logic [3:0] pend, logic [3:0] ack);
        vec_t r;
        r.rst = rst; r.irq = irq; r.mwe = mwe; r.mwd = mwd; r.swe = swe; r.swd = swd;
        r.eret = er; r.pc = pc; r.take = take; r.vec = va; r.epc = e; r.id = id;
        r.insvc = insvc; r.gie = gie; r.pend = pend; r.ack = ack;
        return r;
    endfunction

    task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
            n_err++;
        end
    endtask

    initial begin
        reset = 1'b1; irq_in = 4'b0000; mask_we = 1'b0; mask_wd = 4'b0000;
        status_we = 1'b0; status_wd = 1'b0; eret = 1'b0; pc_next = 32'h0;
        repeat (2) @(posedge clk);

        //        rst  irq     mwe  mwd     swe  swd  eret pc          take vec         epc         id    svc  gie  pend    ack
        tbl.push_back(v(1'b0,4'b0000,1'b1,4'b1011,1'b1,1'b1,1'b0,32'h00,    1'b0,32'h0,     32'h00,     2'd0,1'b0,1'b0,4'b0000,4'b0000));
        tbl.push_back(v(1'b0,4'b0100,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h00,    1'b0,32'h0,     32'h00,     2'd0,1'b0,1'b1,4'b0000,4'b0000));
        tbl.push_back(v(1'b0,4'b0100,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h00,    1'b0,32'h0,     32'h00,     2'd0,1'b0,1'b1,4'b0100,4'b0000));
        tbl.push_back(v(1'b0,4'b0101,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h00,    1'b0,32'h0,     32'h00,     2'd0,1'b0,1'b1,4'b0100,4'b0000));
        tbl.push_back(v(1'b0,4'b0101,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h40,    1'b1,32'h100,   32'h00,     2'd0,1'b0,1'b1,4'b0101,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h44,    1'b0,32'h0,     32'h40,     2'd0,1'b1,1'b1,4'b0100,4'b0001));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b1,32'h48,    1'b0,32'h0,     32'h40,     2'd0,1'b1,1'b1,4'b0100,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b1,4'b1111,1'b0,1'b0,1'b0,32'h40,    1'b0,32'h0,     32'h40,     2'd0,1'b0,1'b1,4'b0100,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h50,    1'b1,32'h120,   32'h40,     2'd0,1'b0,1'b1,4'b0100,4'b0000));
        tbl.push_back(v(1'b0,4'b1010,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h54,    1'b0,32'h0,     32'h50,     2'd2,1'b1,1'b1,4'b0000,4'b0100));
        tbl.push_back(v(1'b0,4'b1010,1'b0,4'b0000,1'b0,1'b0,1'b1,32'h58,    1'b0,32'h0,     32'h50,     2'd2,1'b1,1'b1,4'b1010,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h50,    1'b1,32'h110,   32'h50,     2'd2,1'b0,1'b1,4'b1010,4'b0000));
        tbl.push_back(v(1'b0,4'b0001,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h200,   1'b0,32'h0,     32'h50,     2'd1,1'b1,1'b1,4'b1000,4'b0010));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b1,32'h204,   1'b0,32'h0,     32'h50,     2'd1,1'b1,1'b1,4'b1001,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h54,    1'b1,32'h100,   32'h50,     2'd1,1'b0,1'b1,4'b1001,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b1,32'h300,   1'b0,32'h0,     32'h54,     2'd0,1'b1,1'b1,4'b1000,4'b0001));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h58,    1'b1,32'h130,   32'h54,     2'd0,1'b0,1'b1,4'b1000,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b1,32'h400,   1'b0,32'h0,     32'h58,     2'd3,1'b1,1'b1,4'b0000,4'b1000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b1,1'b0,1'b0,32'h5c,    1'b0,32'h0,     32'h58,     2'd3,1'b0,1'b1,4'b0000,4'b0000));
        tbl.push_back(v(1'b0,4'b0100,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h00,    1'b0,32'h0,     32'h58,     2'd3,1'b0,1'b0,4'b0000,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b1,32'h00,    1'b0,32'h0,     32'h58,     2'd3,1'b0,1'b0,4'b0100,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b1,1'b1,1'b0,32'h00,    1'b0,32'h0,     32'h58,     2'd3,1'b0,1'b0,4'b0100,4'b0000));
        tbl.push_back(v(1'b0,4'b0100,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h60,    1'b1,32'h120,   32'h58,     2'd3,1'b0,1'b1,4'b0100,4'b0000));
        tbl.push_back(v(1'b0,4'b0100,1'b0,4'b0000,1'b0,1'b0,1'b1,32'h500,   1'b0,32'h0,     32'h60,     2'd2,1'b1,1'b1,4'b0100,4'b0100));
        tbl.push_back(v(1'b0,4'b0100,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h64,    1'b1,32'h120,   32'h60,     2'd2,1'b0,1'b1,4'b0100,4'b0000));
        tbl.push_back(v(1'b0,4'b1010,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h68,    1'b0,32'h0,     32'h64,     2'd2,1'b1,1'b1,4'b0000,4'b0100));
        tbl.push_back(v(1'b1,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h00,    1'b0,32'h0,     32'h64,     2'd2,1'b1,1'b1,4'b1010,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b1,4'b1111,1'b1,1'b0,1'b0,32'h00,    1'b0,32'h0,     32'h00,     2'd0,1'b0,1'b0,4'b0000,4'b0000));
        tbl.push_back(v(1'b0,4'b1111,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h00,    1'b0,32'h0,     32'h00,     2'd0,1'b0,1'b0,4'b0000,4'b0000));
        tbl.push_back(v(1'b0,4'b1111,1'b0,4'b0000,1'b1,1'b1,1'b0,32'h00,    1'b0,32'h0,     32'h00,     2'd0,1'b0,1'b0,4'b1111,4'b0000));
        tbl.push_back(v(1'b0,4'b1111,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h70,    1'b1,32'h100,   32'h00,     2'd0,1'b0,1'b1,4'b1111,4'b0000));
        tbl.push_back(v(1'b0,4'b0000,1'b0,4'b0000,1'b0,1'b0,1'b0,32'h74,    1'b0,32'h0,     32'h70,     2'd0,1'b1,1'b1,4'b1110,4'b0001));

        // Drive on the falling edge, check just after, then let the rising edge commit.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; irq_in = tbl[i].irq; mask_we = tbl[i].mwe; mask_wd = tbl[i].mwd;
            status_we = tbl[i].swe; status_wd = tbl[i].swd; eret = tbl[i].eret; pc_next = tbl[i].pc;
            #2;
            n_vec++;
            check("int_take",   i, 32'(int_take),   32'(tbl[i].take));
            if (tbl[i].vec != 32'h0) check("vec_addr", i, vec_addr, tbl[i].vec);
            check("epc",        i, epc,             tbl[i].epc);
            check("int_id",     i, 32'(int_id),     32'(tbl[i].id));
            check("in_service", i, 32'(in_service), 32'(tbl[i].insvc));
            check("status_bit", i, 32'(status_bit), 32'(tbl[i].gie));
            check("pending",    i, 32'(pending),    32'(tbl[i].pend));
            check("irq_ack",    i, 32'(irq_ack),    32'(tbl[i].ack));
        end

        // Request held high through reset must register as an edge right after reset.
        @(negedge clk);
        reset = 1'b1; irq_in = 4'b0001; mask_we = 1'b0; status_we = 1'b0; eret = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        n_vec++;
        check("held_pend_pre",  100, 32'(pending),    32'h0);
        check("held_insvc",     100, 32'(in_service), 32'h0);
        @(negedge clk);
        #2;
        n_vec++;
        check("held_pend_post", 101, 32'(pending),    32'h1);
        check("held_no_take",   101, 32'(int_take),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
